// File: rtl/systolic_host_ctrl.sv
// Host-side initiator for the 4x4 int8 systolic array: packs A/B row words, pulses start,
// captures the 512-bit result and drains it as 16 words. Optional watchdog: SYSTOLIC_TIMEOUT_EN.
module systolic_host_ctrl #(
    parameter int N              = 4,
    parameter int ACC_W          = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         mm_valid_in,
    output logic [127:0] mm_matrix_A,
    output logic [127:0] mm_matrix_B,
    input  logic [511:0] mm_y,
    input  logic         mm_done,
    output logic         busy,
    output logic         err_timeout
);

    // Both streams move a word only on a cycle where valid and ready are high together.
    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [127:0]   a_reg;
    logic [127:0]   b_reg;
    logic [511:0]   res_reg;
    logic [6:0]     row_lsb;
    logic [8:0]     word_lsb;
    logic           in_fire;
    logic           out_fire;

    // Row k sits at [127-32k -: 32]; result word i at [511-32i -: 32].
    assign row_lsb  = {~cnt[1:0], 5'b0};
    assign word_lsb = {~cnt, 5'b0};

    assign in_ready    = (state == S_LOAD);
    assign out_valid   = (state == S_DRAIN);
    assign mm_valid_in = (state == S_START);
    assign busy        = (state != S_LOAD);
    assign out_data    = res_reg[word_lsb +: 32];
    assign out_last    = (state == S_DRAIN) && (cnt == 4'd15);
    assign mm_matrix_A = a_reg;
    assign mm_matrix_B = b_reg;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;

`ifdef SYSTOLIC_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_hit;
    // Fires so that the pulse is visible TIMEOUT_CYCLES cycles after the START cycle.
    assign wd_hit = (wd_cnt == 16'(TIMEOUT_CYCLES - 2));
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_LOAD;
            cnt     <= 4'd0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
`ifdef SYSTOLIC_TIMEOUT_EN
            wd_cnt      <= 16'd0;
            err_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        if (cnt[2] == 1'b0) a_reg[row_lsb +: 32] <= in_data;
                        else                b_reg[row_lsb +: 32] <= in_data;
                        if (cnt[2:0] == 3'd7) begin
                            state <= S_START;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT_LO;
                    cnt   <= 4'd0;
                end
                // A done flag still high from the previous job must fall before it counts.
                S_WAIT_LO: begin
                    if (!mm_done) state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (mm_done) begin
                        res_reg <= mm_y;
                        state   <= S_DRAIN;
                        cnt     <= 4'd0;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        if (cnt == 4'd15) begin
                            state <= S_LOAD;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                    cnt   <= 4'd0;
                end
            endcase

`ifdef SYSTOLIC_TIMEOUT_EN
            err_timeout <= 1'b0;
            if (state == S_WAIT_LO || state == S_WAIT_HI) begin
                if (wd_hit && !(state == S_WAIT_HI && mm_done)) begin
                    err_timeout <= 1'b1;
                    state       <= S_LOAD;
                    cnt         <= 4'd0;
                    res_reg     <= '0;
                    wd_cnt      <= 16'd0;
                end else begin
                    wd_cnt <= wd_cnt + 16'd1;
                end
            end else begin
                wd_cnt <= 16'd0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_systolic_host_ctrl.sv
// Directed bench for systolic_host_ctrl; the bench itself plays the systolic array.
module tb_systolic_host_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic         mm_valid_in;
    logic [127:0] mm_matrix_A;
    logic [127:0] mm_matrix_B;
    logic [511:0] mm_y = '0;
    logic         mm_done = 1'b0;
    logic         busy;
    logic         err_timeout;

    int compared   = 0;
    int mismatched = 0;
    int start_cnt  = 0;

    systolic_host_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mm_valid_in(mm_valid_in), .mm_matrix_A(mm_matrix_A), .mm_matrix_B(mm_matrix_B),
        .mm_y(mm_y), .mm_done(mm_done), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mm_valid_in === 1'b1) start_cnt++;

    localparam logic [255:0] JOB_ID = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001,
                                       32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    localparam logic [255:0] JOB_SG = {{4{32'hFFFFFFFF}}, {4{32'h01010101}}};
    localparam logic [255:0] JOB_NG = {32'hFF000000, 32'h00FF0000, 32'h0000FF00, 32'h000000FF,
                                       32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};

    task automatic check_idle(input string tag);
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || mm_valid_in !== 1'b0 ||
            busy !== 1'b0 || err_timeout !== 1'b0 || out_data !== 32'd0 || mm_matrix_A !== '0) begin
            mismatched++;
            $display("FAIL %s: rdy=%b ov=%b last=%b start=%b busy=%b to=%b data=%h A=%h, required 1 0 0 0 0 0 0 0",
                     tag, in_ready, out_valid, out_last, mm_valid_in, busy, err_timeout, out_data, mm_matrix_A);
        end
    endtask

    // Caller is at a negedge; every word presented is transferred on the next posedge.
    task automatic load_job(input logic [255:0] w, input int gap_pct);
        for (int i = 0; i < 8; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = w[255 - 32*i -: 32];
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL load_ready word %0d: in_ready=%b, required 1", i, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Array model: waits for the start strobe, multiplies the operand buses, then completes.
    task automatic array_respond();
        logic [511:0] y;
        byte          a, b;
        int           acc, n;
        n = 0;
        while (mm_valid_in !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (mm_valid_in !== 1'b1) begin
            mismatched++;
            $display("FAIL start_seen: mm_valid_in=%b after %0d cycles, required 1", mm_valid_in, n);
        end
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) begin
                    a = mm_matrix_A[127 - 32*r - 8*k -: 8];
                    b = mm_matrix_B[127 - 32*k - 8*c -: 8];
                    acc += int'(a) * int'(b);
                end
                y[511 - 32*(4*r + c) -: 32] = acc;
            end
        @(negedge clk);
        compared++;
        if (mm_valid_in !== 1'b0) begin
            mismatched++;
            $display("FAIL start_one_cycle: mm_valid_in=%b, required 0", mm_valid_in);
        end
        if (mm_done === 1'b1) begin
            mm_y = y;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                compared++;
                if (out_valid !== 1'b0 || busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL stale_done: out_valid=%b busy=%b, required 0 1", out_valid, busy);
                end
            end
        end
        mm_done = 1'b0;
        repeat (2) @(negedge clk);
        mm_y    = y;
        mm_done = 1'b1;
        @(negedge clk);
    endtask

    // stop_at < 16 returns while word stop_at is on the bus, without transferring it.
    task automatic drain(input logic [511:0] exp, input bit toggle, input int stop_at);
        int idx, n;
        idx = 0;
        n   = 0;
        while (idx < 16 && n < 200) begin
            compared++;
            if (out_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL drain_valid idx %0d: out_valid=%b, required 1", idx, out_valid);
            end else begin
                compared += 3;
                if (out_data !== exp[511 - 32*idx -: 32]) begin
                    mismatched++;
                    $display("FAIL drain_data idx %0d: got %h, required %h", idx, out_data, exp[511 - 32*idx -: 32]);
                end
                if (out_last !== (idx == 15)) begin
                    mismatched++;
                    $display("FAIL drain_last idx %0d: got %b, required %b", idx, out_last, idx == 15);
                end
                if (in_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL drain_in_ready idx %0d: got %b, required 0", idx, in_ready);
                end
                if (idx == stop_at) break;
            end
            out_ready = toggle ? ~out_ready : 1'b1;
            if (out_ready && out_valid === 1'b1) idx++;
            @(negedge clk);
            n++;
        end
        if (stop_at >= 16) begin
            compared++;
            if (idx != 16 || out_valid !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL drain_end: words=%0d out_valid=%b busy=%b, required 16 0 0", idx, out_valid, busy);
            end
            out_ready = 1'b0;
        end
    endtask

    function automatic logic [511:0] seq_result(input int scale);
        logic [511:0] e;
        for (int k = 0; k < 16; k++) e[511 - 32*k -: 32] = scale * (k + 1);
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset_released");
    endtask

    task automatic test_identity();
        int s0;
        s0 = start_cnt;
        load_job(JOB_ID, 0);
        compared++;
        if (mm_matrix_A !== 128'h01000000_00010000_00000100_00000001 ||
            mm_matrix_B !== 128'h01020304_05060708_090A0B0C_0D0E0F10) begin
            mismatched++;
            $display("FAIL pack_AB: A=%h B=%h", mm_matrix_A, mm_matrix_B);
        end
        array_respond();
        drain(seq_result(1), 1'b0, 16);
        compared++;
        if (start_cnt != s0 + 1) begin
            mismatched++;
            $display("FAIL start_count: got %0d pulses, required 1", start_cnt - s0);
        end
    endtask

    task automatic test_signed();
        load_job(JOB_SG, 0);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        array_respond();
        drain({16{32'hFFFFFFFC}}, 1'b0, 16);
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        load_job(JOB_ID, 50);
        array_respond();
        out_ready = 1'b1;
        drain(seq_result(1), 1'b1, 16);
    endtask

    task automatic test_back_to_back();
        load_job(JOB_SG, 0);
        array_respond();
        drain({16{32'hFFFFFFFC}}, 1'b0, 16);
        load_job(JOB_NG, 0);
        compared++;
        if (mm_matrix_A !== 128'hFF000000_00FF0000_0000FF00_000000FF || mm_done !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_setup: A=%h mm_done=%b", mm_matrix_A, mm_done);
        end
        array_respond();
        drain(seq_result(-1), 1'b0, 16);
    endtask

    task automatic test_reset_mid_drain();
        load_job(JOB_SG, 0);
        array_respond();
        drain({16{32'hFFFFFFFC}}, 1'b0, 8);
        reset = 1'b1;
        #1;
        check_idle("reset_mid_drain");
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_identity();
    endtask

`ifdef SYSTOLIC_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit seen_valid;
        mm_done = 1'b0;
        load_job(JOB_ID, 0);
        n = 0;
        while (mm_valid_in !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        seen_valid = 1'b0;
        while (err_timeout !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        compared++;
        if (n != 256 || busy !== 1'b0 || seen_valid) begin
            mismatched++;
            $display("FAIL timeout: pulse after %0d cycles busy=%b out_valid_seen=%b, required 256 0 0",
                     n, busy, seen_valid);
        end
        @(negedge clk);
        compared++;
        if (err_timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_pulse_width: err_timeout=%b, required 0", err_timeout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_stall();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef SYSTOLIC_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/systolic_host_ctrl.md
Name: systolic_host_ctrl

Overview:
Host-side initiator for the 4x4 int8 systolic matrix-multiply array. Accepts matrix A and matrix B as a stream of 32-bit row words and packs them into the array's 128-bit operand buses. Issues the one-cycle start strobe, waits for completion, then captures the 512-bit result. Drains the result as 16 32-bit words over a valid/ready stream, with a last flag on the final word.

Parameters:
N, 4, matrix dimension; only 4 is supported and it fixes all bus widths below
ACC_W, 32, result element width; only 32 is supported
TIMEOUT_CYCLES, 256, watchdog limit in cycles, used only when the optional feature is compiled in

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input word valid
in_ready  out  1  controller accepts an input word
in_data  in  32  row word; [31:24]=col0 element, [7:0]=col3 element
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts a result word
out_data  out  32  signed result element C[r][c]
out_last  out  1  high with the 16th result word
mm_valid_in  out  1  start strobe to the array
mm_matrix_A  out  128  packed A; [127:96]=row0 ... [31:0]=row3
mm_matrix_B  out  128  packed B, same packing as A
mm_y  in  512  array result; [511:480]=C00, [479:448]=C01, ... [31:0]=C33
mm_done  in  1  array completion flag; may stay high after completion
busy  out  1  high in every state except LOAD
err_timeout  out  1  one-cycle watchdog pulse; tied 0 when the feature is absent

Behaviour:
- Reset is asynchronous and active-high on clk.
- Reset values: state LOAD, word counter 0, A/B/result registers 0. Outputs at reset: in_ready=1 (follows state), out_valid=0, out_last=0, mm_valid_in=0, busy=0, err_timeout=0. out_data=0 because the result register is 0.
- Word transfer on either stream happens only on a cycle where valid and ready are both high.
- State LOAD: in_ready=1.
  - Words 0-3 go to A rows 0-3; words 4-7 go to B rows 0-3, at bit position [127-32k -: 32].
  - Gaps in in_valid are allowed.
  - After the 8th word is accepted, go to START on the next edge.
- State START: mm_valid_in=1 for exactly one cycle; in_ready=0. Next state is WAIT_LO.
- State WAIT_LO: ignores a stale high mm_done left over from the previous job. Moves to WAIT_HI on the first cycle mm_done=0.
- State WAIT_HI: on the first cycle mm_done=1, register mm_y into the result register (one-cycle capture) and go to DRAIN.
- mm_matrix_A and mm_matrix_B are driven from registers, hold from START until the next LOAD completes, and are never changed while busy=1.
- State DRAIN:
  - out_valid=1.
  - out_data = result word idx, row-major: idx 0 is C00 = mm_y[511:480]; idx 15 is C33 = mm_y[31:0].
  - out_last = (idx==15).
  - out_data and out_last stay stable while out_ready=0.
  - idx increments on each transfer. After the idx-15 transfer, idx returns to 0 and the state returns to LOAD.
- The word counter is 3 bits in LOAD and 4 bits in DRAIN, shared, and cleared on every state entry.
- No arithmetic in this block; elements pass through bit-exact (signed 32-bit two's complement).
- Reset mid-operation: immediate return to reset values; the partial load or drain is discarded. mm_valid_in cannot glitch high.
- mm_done high while in LOAD or START is ignored.
- No input word is accepted while busy=1; in_valid is ignored in every state but LOAD.

Optional Feature:
SYSTOLIC_TIMEOUT_EN
- Defined:
  - A 16-bit cycle counter runs while in WAIT_LO or WAIT_HI.
  - On reaching TIMEOUT_CYCLES without a capture: err_timeout=1 for one cycle, the state returns to LOAD, and the result register and counters are cleared.
  - The counter clears on entry to START.
- Undefined: no counter is built, err_timeout is tied 0, and the controller waits indefinitely.

Test Plan:
1. Identity times sequence: A=I (row words 0x01000000, 0x00010000, 0x00000100, 0x00000001); B rows 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10; out_ready=1 -> mm_valid_in pulses exactly once; out_data sequence is 1..16; out_last only on the word with value 16.
2. Signed data: all A bytes 0xFF, all B bytes 0x01 -> all 16 out_data = 0xFFFFFFFC.
3. Handshake stall: in_valid 50% random, out_ready toggled every cycle -> result identical to scenario 1; no word dropped or duplicated; out_data stable while stalled.
4. Back-to-back jobs with mm_done left high from job 1 -> job 2 captures only after mm_done has fallen and risen again; job 2 results are correct.
5. Reset asserted on the 9th drain word -> all outputs return to reset values; a fresh job then completes correctly.
6. With SYSTOLIC_TIMEOUT_EN defined and mm_done held 0 -> err_timeout pulses 256 cycles after START, the block returns to LOAD (busy=0), and no out_valid is ever seen.
